// File: rtl/fifo_uart_word_tx.sv
// Pops 32-bit words from the debug FIFO and sends each as WORD_BYTES 8N1 UART frames,
// most-significant byte first, LSB-first within each byte, paced by an oversampling tick.
module fifo_uart_word_tx #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICK    = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_tick,
    input  logic                    i_fifo_empty,
    input  logic [8*WORD_BYTES-1:0] i_fifo_data,
    output logic                    o_fifo_rd_en,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic                    o_word_done
);

    localparam int WW = 8 * WORD_BYTES;
    localparam int TW = (SB_TICK    > 1) ? $clog2(SB_TICK)    : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;
    localparam int YW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [YW-1:0] BYTE_LAST = YW'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   shift_q, shift_d;
    logic [TW-1:0]   tick_q,  tick_d;
    logic [BW-1:0]   bit_q,   bit_d;
    logic [YW-1:0]   byte_q,  byte_d;
    logic            rd_en_q, rd_en_d;
    logic            tx_q,    tx_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [7:0]      cur_byte;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        rd_en_d  = 1'b0;
        done_d   = 1'b0;
        tx_d     = 1'b1;
        cur_byte = '0;

        case (state_q)
            S_IDLE: begin
                if (!i_fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            // First RD_WAIT cycle overlaps the pop strobe; read data is captured one cycle later.
            S_RD_WAIT: begin
                if (!rd_en_q) begin
                    shift_d = i_fifo_data;
                    byte_d  = '0;
                    tick_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (byte_q == BYTE_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            byte_d  = byte_q + 1'b1;
                            shift_d = shift_q << 8;
                            state_d = S_START;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level is derived from the next state so o_tx stays registered and aligned with it.
        cur_byte = shift_d[WW-1 -: 8];
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            rd_en_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rd_en_q <= rd_en_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_fifo_rd_en = rd_en_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_word_done  = done_q;

endmodule
